// File: rtl/cvxif_copro_pkg.sv
// Shared constants and types for the CV-X-IF example coprocessor responder.
// Covers the custom-3 encodings, the decoded operation and the responder FSM states.
package cvxif_copro_pkg;

    localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;
    localparam logic [6:0] FUNCT7_COPRO   = 7'b0000000;
    localparam logic [2:0] F3_ADD         = 3'b000;
    localparam logic [2:0] F3_NOP         = 3'b001;
    localparam logic [2:0] F3_ADD_MULTI   = 3'b010;

    typedef enum logic [1:0] {
        OP_ADD       = 2'd0,
        OP_NOP       = 2'd1,
        OP_ADD_MULTI = 2'd2,
        OP_NONE      = 2'd3
    } copro_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_CMT = 2'd2,
        RESP     = 2'd3
    } state_e;

    typedef struct packed {
        logic      accept;
        logic      we;
        copro_op_e op;
        logic [4:0] rd;
    } decode_t;

    // Source operands an operation reads, as a {rs2,rs1} valid mask.
    function automatic logic [1:0] rs_needed(input copro_op_e op);
        case (op)
            OP_ADD, OP_ADD_MULTI: rs_needed = 2'b11;
            default:              rs_needed = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/copro_decoder.sv
// Combinational decode of an offered custom-3 instruction.
// Accept only when the encoding is known and every operand it reads is valid.
module copro_decoder
    import cvxif_copro_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [1:0]  rs_valid,
    output decode_t     dec
);

    // Register-index fields are not needed: operand values arrive on the rs bus.
    logic unused_fields;
    assign unused_fields = ^instr[24:15];

    copro_op_e op;
    logic      accept;

    always_comb begin
        op = OP_NONE;
        if (instr[6:0] == OPCODE_CUSTOM3 && instr[31:25] == FUNCT7_COPRO) begin
            case (instr[14:12])
                F3_ADD:       op = OP_ADD;
                F3_NOP:       op = OP_NOP;
                F3_ADD_MULTI: op = OP_ADD_MULTI;
                default:      op = OP_NONE;
            endcase
        end
        accept     = (op != OP_NONE) && ((rs_valid & rs_needed(op)) == rs_needed(op));
        dec.accept = accept;
        dec.we     = accept && (op != OP_NOP);
        dec.op     = op;
        dec.rd     = instr[11:7];
    end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder: takes one custom-3 offload at a time, executes it,
// waits for the matching commit (or kill) and returns the result.
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned HART_W    = 1,
    parameter int unsigned MULTI_LAT = 3
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [HART_W-1:0]   issue_hartid_i,
    input  logic [2*XLEN-1:0]   issue_rs_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic [HART_W-1:0]   commit_hartid_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [HART_W-1:0]   result_hartid_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output state_e              dbg_state_o
);

    localparam int unsigned CNT_W = (MULTI_LAT > 1) ? $clog2(MULTI_LAT) : 1;
    localparam logic [CNT_W-1:0] MULTI_CNT = CNT_W'(MULTI_LAT - 1);

    decode_t dec;

    copro_decoder u_decoder (
        .instr    (issue_instr_i),
        .rs_valid (issue_rs_valid_i),
        .dec      (dec)
    );

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                committed_q;
    logic                valid_q;
    logic                we_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [HART_W-1:0]   hart_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     data_q;

    logic            issue_hs;
    logic            commit_match;
    logic            kill_match;
    logic            commit_ok;
    logic            commit_done;
    logic [XLEN-1:0] op_result;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // issue: ready only in IDLE; result: valid is held, with data stable, until ready.
    assign issue_ready_o     = (state_q == IDLE);
    assign issue_hs          = issue_valid_i & issue_ready_o;
    assign issue_accept_o    = issue_hs & dec.accept;
    assign issue_writeback_o = issue_hs & dec.we;

    // Only meaningful outside IDLE; in IDLE the stored id/hart are stale and ignored.
    assign commit_match = commit_valid_i && (commit_id_i == id_q) && (commit_hartid_i == hart_q);
    assign kill_match   = commit_match & commit_kill_i;
    assign commit_ok    = commit_match & ~commit_kill_i;
    assign commit_done  = committed_q | commit_ok;

    assign op_result = (dec.op == OP_NOP) ? '0
                     : issue_rs_i[XLEN-1:0] + issue_rs_i[2*XLEN-1:XLEN];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            committed_q <= 1'b0;
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            id_q        <= '0;
            hart_q      <= '0;
            rd_q        <= '0;
            data_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_accept_o) begin
                        state_q     <= EXEC;
                        cnt_q       <= (dec.op == OP_ADD_MULTI) ? MULTI_CNT : '0;
                        committed_q <= 1'b0;
                        id_q        <= issue_id_i;
                        hart_q      <= issue_hartid_i;
                        rd_q        <= dec.rd;
                        we_q        <= dec.we;
                        data_q      <= op_result;
                    end
                end
                EXEC: begin
                    if (kill_match) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        if (commit_done) begin
                            state_q <= RESP;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= WAIT_CMT;
                        end
                    end else begin
                        cnt_q       <= cnt_q - 1'b1;
                        committed_q <= commit_done;
                    end
                end
                WAIT_CMT: begin
                    if (kill_match) begin
                        state_q <= IDLE;
                    end else if (commit_ok) begin
                        state_q <= RESP;
                        valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    // Past the point of no return: a late kill cannot retract the result.
                    if (result_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_valid_o  = valid_q;
    assign result_id_o     = id_q;
    assign result_hartid_o = hart_q;
    assign result_data_o   = data_q;
    assign result_rd_o     = rd_q;
    assign result_we_o     = we_q;
    assign dbg_state_o     = state_q;

endmodule
